// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and lane helpers for pipeline boundary registers
package pipe_pkg;
    localparam int FLUSH_DATA = 0;
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data entry with clear (priority), load and hold controls
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid <= 1'b0;
            r_data  <= W'(FLUSH_DATA);
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= W'(FLUSH_DATA);
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with optional skid entry,
// stall hold, flush-to-bubble and a saturating flush-drop counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic [LANES*DATA_W-1:0] In_Data,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [LANES*DATA_W-1:0] Out_Data,
    input  logic                    Stall,
    input  logic                    Flush,
    output logic [1:0]              Occupancy,
    output logic [CNT_W-1:0]        Flush_Drops
);
    localparam int W = LANES * DATA_W;
    logic         w_m_valid, w_s_valid, w_in_ready, w_in_fire, w_out_fire;
    logic         w_m_from_s, w_m_load, w_m_clear;
    logic [W-1:0] w_m_data, w_s_data, w_m_din;
    logic [CNT_W:0] w_sum;
    logic [CNT_W-1:0] r_flush_drops;
    assign Out_Valid  = w_m_valid & ~Stall & ~Flush;
    assign In_Ready   = w_in_ready;
    assign w_in_fire  = In_Valid & w_in_ready;
    assign w_out_fire = Out_Valid & Out_Ready;
    // M refills from S only when draining with no new word arriving
    assign w_m_from_s = w_out_fire & ~w_in_fire & w_s_valid;
    assign w_m_load   = (w_in_fire & (~w_m_valid | w_out_fire)) | w_m_from_s;
    assign w_m_clear  = Flush | (w_out_fire & ~w_in_fire & ~w_s_valid);
    assign w_m_din    = w_m_from_s ? w_s_data : In_Data;
    pipe_slot #(.W(W)) u_m (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_data  (w_m_din),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );
    if (SKID != 0) begin : g_skid
        pipe_slot #(.W(W)) u_s (
            .Clock   (Clock),
            .Reset_n (Reset_n),
            .i_load  (w_in_fire & w_m_valid & ~w_out_fire),
            .i_clear (Flush | (w_out_fire & w_s_valid)),
            .i_data  (In_Data),
            .o_valid (w_s_valid),
            .o_data  (w_s_data)
        );
        assign w_in_ready = ~w_s_valid & ~Stall & ~Flush;
    end else begin : g_noskid
        assign w_s_valid  = 1'b0;
        assign w_s_data   = '0;
        assign w_in_ready = ~Stall & ~Flush & (~w_m_valid | Out_Ready);
    end
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign Out_Data[lane_lo(k, DATA_W) +: DATA_W] = w_m_data[lane_lo(k, DATA_W) +: DATA_W];
    end
    assign Occupancy = {1'b0, w_m_valid} + {1'b0, w_s_valid};
    assign w_sum     = {1'b0, r_flush_drops} + {{(CNT_W-1){1'b0}}, Occupancy};
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            r_flush_drops <= '0;
        else if (Flush)
            r_flush_drops <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
    assign Flush_Drops = r_flush_drops;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a SKID=1 (CNT_W=2) and a SKID=0 instance with the same
// inputs and compares both against queue-based reference models
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [63:0] in_data = '0;
    logic        ir1, ov1, ir0, ov0;
    logic [63:0] od1, od0;
    logic [1:0]  occ1, occ0;
    logic [1:0]  fd1;
    logic [15:0] fd0;
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    int d1 = 0, d0 = 0;
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    pipe_stage_reg #(.DATA_W(32), .LANES(2), .SKID(1), .CNT_W(2)) dut1 (
        .Clock(clk), .Reset_n(rst_n), .In_Valid(in_valid), .In_Ready(ir1), .In_Data(in_data),
        .Out_Valid(ov1), .Out_Ready(out_ready), .Out_Data(od1), .Stall(stall), .Flush(flush),
        .Occupancy(occ1), .Flush_Drops(fd1)
    );
    pipe_stage_reg #(.DATA_W(32), .LANES(2), .SKID(0), .CNT_W(16)) dut0 (
        .Clock(clk), .Reset_n(rst_n), .In_Valid(in_valid), .In_Ready(ir0), .In_Data(in_data),
        .Out_Valid(ov0), .Out_Ready(out_ready), .Out_Data(od0), .Stall(stall), .Flush(flush),
        .Occupancy(occ0), .Flush_Drops(fd0)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic cycle(input logic iv, input logic ordy, input logic st, input logic fl,
                         input logic [63:0] d);
        logic e_ov1, e_ir1, e_ov0, e_ir0;
        @(negedge clk);
        in_valid = iv; out_ready = ordy; stall = st; flush = fl; in_data = d;
        #1;
        e_ov1 = q1.size() > 0 && !st && !fl;
        e_ir1 = q1.size() < 2 && !st && !fl;
        e_ov0 = q0.size() > 0 && !st && !fl;
        e_ir0 = !st && !fl && (q0.size() == 0 || ordy);
        chk("ov1", ov1, e_ov1);
        chk("ir1", ir1, e_ir1);
        chk("od1", od1, q1.size() > 0 ? q1[0] : 64'd0);
        chk("occ1", occ1, q1.size());
        chk("fd1", fd1, d1);
        chk("ov0", ov0, e_ov0);
        chk("ir0", ir0, e_ir0);
        chk("od0", od0, q0.size() > 0 ? q0[0] : 64'd0);
        chk("occ0", occ0, q0.size());
        chk("fd0", fd0, d0);
        @(posedge clk);
        if (fl) begin
            d1 = (d1 + q1.size() > 3) ? 3 : d1 + q1.size();
            d0 = (d0 + q0.size() > 65535) ? 65535 : d0 + q0.size();
            q1.delete();
            q0.delete();
        end else if (!st) begin
            if (e_ov1 && ordy) void'(q1.pop_front());
            if (e_ir1 && iv) q1.push_back(d);
            if (e_ov0 && ordy) void'(q0.pop_front());
            if (e_ir0 && iv) q0.push_back(d);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        chk("rst_occ1", occ1, 0);
        chk("rst_ov1", ov1, 0);
        chk("rst_od1", od1, 0);
        chk("rst_fd1", fd1, 0);
        chk("rst_occ0", occ0, 0);
        chk("rst_od0", od0, 0);
        q1.delete(); q0.delete(); d1 = 0; d0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_ir1", ir1, 1);
        chk("init_ir0", ir0, 1);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, {32'h104 + 32'(i), 32'h100 + 32'(i)});
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, {32'h2000, 32'h200 + 32'(i)});
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 64'h0);
        cycle(1, 0, 0, 0, 64'hDEAD);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 64'hBEEF);
        cycle(0, 1, 0, 0, 64'h0);
        cycle(1, 0, 0, 0, 64'h300);
        cycle(1, 0, 0, 0, 64'h301);
        cycle(1, 0, 0, 1, 64'h302);
        cycle(0, 1, 0, 0, 64'h0);
        cycle(1, 0, 0, 0, 64'h400);
        cycle(1, 0, 1, 1, 64'h401);
        cycle(0, 0, 0, 0, 64'h0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 64'h500 + 64'(i));
            cycle(0, 0, 0, 1, 64'h0);
        end
        cycle(0, 0, 0, 0, 64'h0);
        chk("sat_fd1", fd1, 3);
        do_reset();
        for (int i = 0; i < 1500; i++)
            cycle($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 8 == 0, $urandom % 16 == 0,
                  {$urandom, $urandom});
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, {$urandom, $urandom});
        do_reset();
        cycle(0, 0, 0, 0, 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register that carries LANES payload words of DATA_W bits between two pipeline stages, for example the fetch-to-decode boundary. It supports a valid/ready handshake, a hold-on-stall input and a flush input. An optional skid entry lets full throughput coexist with a registered In_Ready. A flushed entry becomes a zero bubble. Stall holds the stored contents instead of discarding them. A saturating counter reports the number of valid entries destroyed by flushes, for the performance counters.

## Interface
Parameters:
- DATA_W, 32, width of one payload lane
- LANES, 2, number of payload lanes (lane 0 = instruction, lane 1 = PC+4 in the fetch/decode use)
- SKID, 1, 1 = two-entry (main + skid), 0 = single entry with combinational ready path
- CNT_W, 16, width of Flush_Drops

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- In_Valid  in  1  upstream offers In_Data
- In_Ready  out  1  block accepts In_Data this cycle
- In_Data  in  LANES*DATA_W  payload; lane k occupies bits [k*DATA_W +: DATA_W]
- Out_Valid  out  1  Out_Data is valid
- Out_Ready  in  1  downstream consumes this cycle
- Out_Data  out  LANES*DATA_W  payload of the main entry
- Stall  in  1  hold all state; no transfers on either side
- Flush  in  1  synchronous kill of all stored entries
- Occupancy  out  2  number of valid entries (0..2; at most 1 when SKID=0)
- Flush_Drops  out  CNT_W  saturating count of valid entries killed by Flush

## Operation
- State:
  - main entry M (valid, data)
  - skid entry S (valid, data), present only when SKID=1
  - Flush_Drops counter
- Handshake signals, all combinational from state and inputs:
  - in_fire = In_Valid & In_Ready
  - out_fire = Out_Valid & Out_Ready
  - Out_Valid = M.valid & ~Stall & ~Flush
  - Out_Data = M.data
- In_Ready:
  - SKID=1: ~S.valid & ~Stall & ~Flush
  - SKID=0: ~Stall & ~Flush & (~M.valid | Out_Ready)
- Priority is Flush > Stall > normal operation.
- Flush:
  - next state has M.valid = S.valid = 0
  - M.data and S.data are cleared to 0
  - input presented that cycle is not accepted
  - Flush_Drops += M.valid + S.valid, saturating at all-ones
- Stall (without Flush): all state holds unchanged; the stored entries are not lost.
- Normal transitions:
  - M empty, in_fire: M <- In.
  - M full, out_fire, in_fire: M <- In. S is necessarily empty here.
  - M full, out_fire, no in_fire: M <- S if S.valid, else M is emptied. S is emptied.
  - M full, no out_fire, in_fire (SKID=1 only): S <- In.
  - Otherwise: hold.
- Data clearing: whenever an entry's valid goes 0, its data is cleared to 0. Out_Data is therefore 0 whenever M is empty, which keeps bubbles benign for decode.
- Occupancy = M.valid + S.valid.

## Timing
- Reset (async, Reset_n=0) gives:
  - M.valid = S.valid = 0, all data = 0
  - Out_Valid = 0, Out_Data = 0, Occupancy = 0, Flush_Drops = 0
  - In_Ready = 1 once Reset_n is deasserted, provided Stall = Flush = 0
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency is 1 cycle: an in_fire at edge N gives Out_Valid at cycle N+1.
- Throughput is 1 transfer per cycle with Out_Ready held high, for both SKID settings.
- SKID=1: In_Ready depends only on S.valid, Stall and Flush. There is no combinational path from Out_Ready to In_Ready.
- Flush and Stall both asserted: Flush wins.
- Flush_Drops at all-ones stays at all-ones.

## Structure
- Shared package pipe_pkg holds:
  - FLUSH_DATA constant (zero) for cleared payloads
  - a lane-slicing helper function used here and by downstream stages
- Sub-module pipe_slot: one valid+data register with load, clear and hold controls.
  - Instantiated as M, and as S under a generate on SKID.

## Test plan
- Reset then stream: 8 consecutive words 0x100..0x107 with Out_Ready=1 → outputs 0x100..0x107 on consecutive cycles, first at cycle 1; Occupancy stays 1.
- Backpressure: Out_Ready=0 for 3 cycles while In_Valid=1 (SKID=1) → accepts 2 words, In_Ready=0 on the third cycle, Occupancy=2; on release, words exit in order with none lost or duplicated.
- Stall: M holds 0xDEAD, assert Stall for 4 cycles → Out_Valid=0 and In_Ready=0 throughout; after release Out_Data=0xDEAD with Out_Valid=1.
- Flush with Occupancy=2 and In_Valid=1 → next cycle Occupancy=0, Out_Data=0, Flush_Drops=2; the word offered in the flush cycle never appears at the output.
- Flush+Stall together with Occupancy=1 → entry killed and Flush_Drops increments by 1. Separately, preload Flush_Drops to saturation (CNT_W=2, 3 flushes of full M, then a 4th) → counter holds at 3.
- SKID=0 build: Out_Ready=0 with M full → In_Ready=0 in the same cycle; Out_Ready=1 with In_Valid=1 → pass-through at 1 word/cycle.
